// File: rtl/neuron_param_bank.sv
// neuron_param_bank: Wishbone-mapped parameter storage for NUM_NEURONS neurons with a core read port and a voltage write-back port
//   wbs_*          : Wishbone slave window at PARAM_BASE, 16 bytes per neuron (words 0..2 used, word 3 reserved)
//   core_rd_*      : registered indexed read of one neuron's parameter set, 1-cycle latency
//   core_wr_*      : voltage-potential write-back; dropped when a same-cycle bus write owns that byte
module neuron_param_bank #(
    parameter int          NUM_NEURONS = 16,
    parameter int          IDX_W       = $clog2(NUM_NEURONS),
    parameter logic [31:0] PARAM_BASE  = 32'h30004000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              core_rd_en_i,
    input  logic [IDX_W-1:0]  core_rd_idx_i,
    output logic              core_rd_valid_o,
    output logic signed [7:0] voltage_potential_o,
    output logic signed [7:0] pos_reset_o,
    output logic signed [7:0] neg_reset_o,
    output logic signed [7:0] leak_value_o,
    output logic signed [7:0] pos_threshold_o,
    output logic signed [7:0] neg_threshold_o,
    output logic signed [7:0] weight_type1_o,
    output logic signed [7:0] weight_type2_o,
    output logic signed [7:0] weight_type3_o,
    output logic signed [7:0] weight_type4_o,
    output logic              weight_select_o,
    input  logic              core_wr_en_i,
    input  logic [IDX_W-1:0]  core_wr_idx_i,
    input  logic [7:0]        core_wr_vp_i,
    output logic              core_wr_drop_o
);
    localparam logic [31:0] WIN = 32'(16 * NUM_NEURONS);

    typedef enum logic {IDLE, ACK} state_t;
    state_t r_state, w_next;

    logic [31:0] r_w0 [NUM_NEURONS];
    logic [31:0] r_w1 [NUM_NEURONS];
    logic [24:0] r_w2 [NUM_NEURONS];

    logic [31:0] r_dat;
    logic        r_valid, r_drop, r_wsel;
    logic [7:0]  r_vp, r_pr, r_nr, r_leak, r_pth, r_nth, r_wt1, r_wt2, r_wt3, r_wt4;

    logic [31:0]      w_off, w_cur, w_mrg, w_r0, w_r1;
    logic [IDX_W-1:0] w_nidx;
    logic [1:0]       w_word;
    logic [24:0]      w_r2;
    logic             w_req, w_valid, w_bwr, w_coll;

    assign w_off   = wbs_adr_i - PARAM_BASE;
    assign w_nidx  = w_off[4 +: IDX_W];
    assign w_word  = w_off[3:2];
    assign w_valid = (wbs_adr_i >= PARAM_BASE) && (w_off < WIN) && (w_word != 2'd3);
    assign w_req   = (r_state == IDLE) && wbs_cyc_i && wbs_stb_i;
    assign w_bwr   = w_req && wbs_we_i && w_valid;
    // Bus wins the voltage byte only when it actually writes lane 1 of the same neuron's word2
    assign w_coll  = core_wr_en_i && w_bwr && (w_word == 2'd2) && (w_nidx == core_wr_idx_i) && wbs_sel_i[1];
    assign w_cur   = (w_word == 2'd0) ? r_w0[w_nidx] :
                     (w_word == 2'd1) ? r_w1[w_nidx] :
                     (w_word == 2'd2) ? {7'd0, r_w2[w_nidx]} : 32'd0;
    assign w_r0    = r_w0[core_rd_idx_i];
    assign w_r1    = r_w1[core_rd_idx_i];
    assign w_r2    = r_w2[core_rd_idx_i];

    always_comb begin
        w_mrg = w_cur;
        for (int i = 0; i < 4; i++) w_mrg[8*i +: 8] = wbs_sel_i[i] ? wbs_dat_i[8*i +: 8] : w_cur[8*i +: 8];
    end

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE && w_req) ? ACK : IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        r_state <= wb_rst_i ? IDLE : w_next;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_w0[i] <= '0;
                r_w1[i] <= '0;
                r_w2[i] <= '0;
            end
        end else begin
            if (w_bwr && w_word == 2'd0) r_w0[w_nidx] <= w_mrg;
            if (w_bwr && w_word == 2'd1) r_w1[w_nidx] <= w_mrg;
            if (w_bwr && w_word == 2'd2) r_w2[w_nidx] <= w_mrg[24:0];
            if (core_wr_en_i && !w_coll) r_w2[core_wr_idx_i][15:8] <= core_wr_vp_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_dat   <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
            r_wsel  <= 1'b0;
            r_vp    <= '0;
            r_pr    <= '0;
            r_nr    <= '0;
            r_leak  <= '0;
            r_pth   <= '0;
            r_nth   <= '0;
            r_wt1   <= '0;
            r_wt2   <= '0;
            r_wt3   <= '0;
            r_wt4   <= '0;
        end else begin
            r_valid <= core_rd_en_i;
            r_drop  <= w_coll;
            if (w_req) r_dat <= w_valid ? w_cur : 32'd0;
            if (core_rd_en_i) begin
                r_wsel <= core_rd_idx_i[0];
                r_vp   <= w_r2[15:8];
                r_pr   <= w_r2[7:0];
                // Hard reset mirrors pos_reset; 8-bit wrap keeps -(-128) at -128
                r_nr   <= w_r2[24] ? w_r2[23:16] : (~w_r2[7:0] + 8'd1);
                r_leak <= w_r0[31:24];
                r_pth  <= w_r0[23:16];
                r_nth  <= w_r0[15:8];
                r_wt1  <= w_r1[31:24];
                r_wt2  <= w_r1[23:16];
                r_wt3  <= w_r1[15:8];
                r_wt4  <= w_r1[7:0];
            end
        end
    end

    assign wbs_ack_o           = (r_state == ACK);
    assign wbs_dat_o           = r_dat;
    assign core_rd_valid_o     = r_valid;
    assign core_wr_drop_o      = r_drop;
    assign weight_select_o     = r_wsel;
    assign voltage_potential_o = r_vp;
    assign pos_reset_o         = r_pr;
    assign neg_reset_o         = r_nr;
    assign leak_value_o        = r_leak;
    assign pos_threshold_o     = r_pth;
    assign neg_threshold_o     = r_nth;
    assign weight_type1_o      = r_wt1;
    assign weight_type2_o      = r_wt2;
    assign weight_type3_o      = r_wt3;
    assign weight_type4_o      = r_wt4;
endmodule
